// File: rtl/snax_gemm_shell_pkg.sv
// Shared types and constants for the GEMM control shell: FSM states, CSR
// indices and status bit positions.
package snax_gemm_shell_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned CsrK     = 0;
  localparam int unsigned CsrN     = 1;
  localparam int unsigned CsrM     = 2;
  localparam int unsigned CsrSub   = 3;
  localparam int unsigned CsrFlags = 4;

  localparam int unsigned CsrBusy   = 0;
  localparam int unsigned CsrPerf   = 1;
  localparam int unsigned CsrStatus = 2;

  localparam int unsigned StErrZeroDim = 0;
  localparam int unsigned StCOverrun   = 1;
  localparam int unsigned FlagCDrop    = 0;

  localparam int unsigned DefDataWidthC = 2048;
  localparam int unsigned DefCSplit     = 4;
  localparam int unsigned NarrowW       = DefDataWidthC / DefCSplit;

  function automatic int unsigned narrow_w(input int unsigned wide_w, input int unsigned split);
    return wide_w / split;
  endfunction

endpackage

// File: rtl/snax_gemm_c_serializer.sv
// Wide-to-narrow C path: one holding register drained as CSplit narrow beats,
// least-significant slice first.
module snax_gemm_c_serializer
  import snax_gemm_shell_pkg::*;
#(
  parameter int unsigned DataWidthC = 2048,
  parameter int unsigned CSplit     = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [DataWidthC-1:0]                    i_wide_data,
  input  logic                                     i_wide_load,
  output logic                                     o_wide_ready,
  output logic                                     o_hold_valid,
  output logic [narrow_w(DataWidthC, CSplit)-1:0]  o_narrow_data,
  output logic                                     o_narrow_valid,
  input  logic                                     i_narrow_ready
);

  localparam int unsigned SliceW = narrow_w(DataWidthC, CSplit);
  localparam int unsigned IdxW   = (CSplit > 1) ? $clog2(CSplit) : 1;

  logic [DataWidthC-1:0] r_hold;
  logic                  r_valid;
  logic [IdxW-1:0]       r_idx;
  logic                  w_last;
  logic                  w_out_fire;

  assign w_last         = (r_idx == IdxW'(CSplit - 1));
  assign w_out_fire     = r_valid && i_narrow_ready;
  // Refill in the same cycle the last slice leaves, so back-to-back results never bubble.
  assign o_wide_ready   = !r_valid || (w_out_fire && w_last);
  assign o_hold_valid   = r_valid;
  assign o_narrow_valid = r_valid;
  assign o_narrow_data  = r_hold[r_idx*SliceW +: SliceW];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (i_wide_load) begin
      r_hold  <= i_wide_data;
      r_valid <= 1'b1;
      r_idx   <= '0;
    end else if (w_out_fire) begin
      if (w_last) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + IdxW'(1);
      end
    end
  end

endmodule

// File: rtl/snax_gemm_shell_ctrl.sv
// Control shell between CSR manager, streamers and GEMM core: latches a job,
// gates A/B to M*K*N beats, serialises C results and reports status.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a configuration; streams and C input closed
//   ST_RUN   | A/B gated to M*K*N beats, C results accepted up to M*N
//   ST_DRAIN | all C results taken; waiting for the holding register
module snax_gemm_shell_ctrl
  import snax_gemm_shell_pkg::*;
#(
  parameter int unsigned RegRWCount   = 5,
  parameter int unsigned RegROCount   = 3,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned DataWidthA   = 512,
  parameter int unsigned DataWidthB   = 512,
  parameter int unsigned DataWidthC   = 2048,
  parameter int unsigned CSplit       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [RegDataWidth-1:0]      csr_reg_set_i [RegRWCount],
  input  logic                         csr_reg_set_valid_i,
  output logic                         csr_reg_set_ready_o,
  output logic [RegDataWidth-1:0]      csr_reg_ro_set_o [RegROCount],
  input  logic [DataWidthA-1:0]        stream2acc_0_data_i,
  input  logic                         stream2acc_0_valid_i,
  output logic                         stream2acc_0_ready_o,
  input  logic [DataWidthB-1:0]        stream2acc_1_data_i,
  input  logic                         stream2acc_1_valid_i,
  output logic                         stream2acc_1_ready_o,
  output logic [DataWidthA-1:0]        core_a_data_o,
  output logic                         core_a_valid_o,
  input  logic                         core_a_ready_i,
  output logic [DataWidthB-1:0]        core_b_data_o,
  output logic                         core_b_valid_o,
  input  logic                         core_b_ready_i,
  output logic                         core_cfg_valid_o,
  output logic [RegDataWidth-1:0]      core_m_o,
  output logic [RegDataWidth-1:0]      core_k_o,
  output logic [RegDataWidth-1:0]      core_n_o,
  output logic [RegDataWidth-1:0]      core_sub_o,
  input  logic [DataWidthC-1:0]        core_c_data_i,
  input  logic                         core_c_valid_i,
  output logic                         core_c_ready_o,
  output logic [DataWidthC/CSplit-1:0] acc2stream_0_data_o,
  output logic                         acc2stream_0_valid_o,
  input  logic                         acc2stream_0_ready_i
);

  localparam logic [RegDataWidth-1:0] DimOne = RegDataWidth'(1);

  state_e                  r_state, w_state_next;
  logic                    w_idle, w_run;
  logic                    w_cfg_fire, w_zero_dim;
  logic [RegDataWidth-1:0] r_cfg_m, r_cfg_k, r_cfg_n, r_cfg_sub;
  logic                    r_c_drop;
  logic                    r_cfg_pulse;
  logic [RegDataWidth-1:0] w_k_last, w_n_last, w_m_last;
  logic [RegDataWidth-1:0] r_ab_k [2];
  logic [RegDataWidth-1:0] r_ab_n [2];
  logic [RegDataWidth-1:0] r_ab_m [2];
  logic [1:0]              r_ab_done;
  logic [1:0]              w_ab_fire;
  logic [RegDataWidth-1:0] r_c_n, r_c_m;
  logic                    w_c_fire, w_c_last;
  logic                    w_ser_ready, w_ser_load, w_hold_valid;
  logic [RegDataWidth-1:0] r_perf;
  logic                    r_err_zero, r_c_overrun;
  logic                    w_unused;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_run      = (r_state == ST_RUN);
  assign w_cfg_fire = csr_reg_set_valid_i && w_idle;
  assign w_zero_dim = (csr_reg_set_i[CsrM] == '0) || (csr_reg_set_i[CsrK] == '0) ||
                      (csr_reg_set_i[CsrN] == '0);
  assign w_unused   = ^csr_reg_set_i[CsrFlags][RegDataWidth-1:1];

  assign csr_reg_set_ready_o = w_idle;

  assign w_k_last = r_cfg_k - DimOne;
  assign w_n_last = r_cfg_n - DimOne;
  assign w_m_last = r_cfg_m - DimOne;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cfg_fire && !w_zero_dim) w_state_next = ST_RUN;
      ST_RUN:   if (w_c_last) w_state_next = ST_DRAIN;
      ST_DRAIN: if (!w_hold_valid) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Config is latched even for zero-dimension jobs so the core ports show what was written.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cfg_m     <= '0;
      r_cfg_k     <= '0;
      r_cfg_n     <= '0;
      r_cfg_sub   <= '0;
      r_c_drop    <= 1'b0;
      r_cfg_pulse <= 1'b0;
    end else begin
      r_cfg_pulse <= w_cfg_fire && !w_zero_dim;
      if (w_cfg_fire) begin
        r_cfg_m   <= csr_reg_set_i[CsrM];
        r_cfg_k   <= csr_reg_set_i[CsrK];
        r_cfg_n   <= csr_reg_set_i[CsrN];
        r_cfg_sub <= csr_reg_set_i[CsrSub];
        r_c_drop  <= csr_reg_set_i[CsrFlags][FlagCDrop];
      end
    end
  end

  assign core_cfg_valid_o = r_cfg_pulse;
  assign core_m_o         = r_cfg_m;
  assign core_k_o         = r_cfg_k;
  assign core_n_o         = r_cfg_n;
  assign core_sub_o       = r_cfg_sub;

  assign core_a_data_o        = stream2acc_0_data_i;
  assign core_b_data_o        = stream2acc_1_data_i;
  assign core_a_valid_o       = w_run && stream2acc_0_valid_i && !r_ab_done[0];
  assign core_b_valid_o       = w_run && stream2acc_1_valid_i && !r_ab_done[1];
  assign stream2acc_0_ready_o = w_run && core_a_ready_i && !r_ab_done[0];
  assign stream2acc_1_ready_o = w_run && core_b_ready_i && !r_ab_done[1];
  assign w_ab_fire[0]         = core_a_valid_o && core_a_ready_i;
  assign w_ab_fire[1]         = core_b_valid_o && core_b_ready_i;

  // Index 0 tracks A, index 1 tracks B; k innermost, then n, then m.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || w_cfg_fire) begin
      for (int s = 0; s < 2; s++) begin
        r_ab_k[s] <= '0;
        r_ab_n[s] <= '0;
        r_ab_m[s] <= '0;
      end
      r_ab_done <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_ab_fire[s]) begin
          if (r_ab_k[s] == w_k_last) begin
            r_ab_k[s] <= '0;
            if (r_ab_n[s] == w_n_last) begin
              r_ab_n[s] <= '0;
              if (r_ab_m[s] == w_m_last) begin
                r_ab_m[s]    <= '0;
                r_ab_done[s] <= 1'b1;
              end else begin
                r_ab_m[s] <= r_ab_m[s] + DimOne;
              end
            end else begin
              r_ab_n[s] <= r_ab_n[s] + DimOne;
            end
          end else begin
            r_ab_k[s] <= r_ab_k[s] + DimOne;
          end
        end
      end
    end
  end

  assign core_c_ready_o = w_run && (r_c_drop || w_ser_ready);
  assign w_c_fire       = core_c_valid_i && core_c_ready_o;
  assign w_c_last       = w_c_fire && (r_c_n == w_n_last) && (r_c_m == w_m_last);
  assign w_ser_load     = w_c_fire && !r_c_drop;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || w_cfg_fire) begin
      r_c_n <= '0;
      r_c_m <= '0;
    end else if (w_c_fire) begin
      if (r_c_n == w_n_last) begin
        r_c_n <= '0;
        r_c_m <= (r_c_m == w_m_last) ? '0 : r_c_m + DimOne;
      end else begin
        r_c_n <= r_c_n + DimOne;
      end
    end
  end

  snax_gemm_c_serializer #(
    .DataWidthC (DataWidthC),
    .CSplit     (CSplit)
  ) u_c_serializer (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .i_wide_data    (core_c_data_i),
    .i_wide_load    (w_ser_load),
    .o_wide_ready   (w_ser_ready),
    .o_hold_valid   (w_hold_valid),
    .o_narrow_data  (acc2stream_0_data_o),
    .o_narrow_valid (acc2stream_0_valid_o),
    .i_narrow_ready (acc2stream_0_ready_i)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf      <= '0;
      r_err_zero  <= 1'b0;
      r_c_overrun <= 1'b0;
    end else begin
      if (w_cfg_fire) begin
        r_perf      <= '0;
        r_err_zero  <= w_zero_dim;
        r_c_overrun <= 1'b0;
      end else if (!w_idle && (r_perf != '1)) begin
        r_perf <= r_perf + DimOne;
      end
      // An overrun seen in the accepting cycle still counts against the new job.
      if (w_idle && core_c_valid_i) r_c_overrun <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(RegROCount); i++) csr_reg_ro_set_o[i] = '0;
    csr_reg_ro_set_o[CsrBusy][0]                = !w_idle;
    csr_reg_ro_set_o[CsrPerf]                   = r_perf;
    csr_reg_ro_set_o[CsrStatus][StErrZeroDim]   = r_err_zero;
    csr_reg_ro_set_o[CsrStatus][StCOverrun]     = r_c_overrun;
  end

endmodule

// File: tb/tb_snax_gemm_shell_ctrl.sv
// Randomised bench for snax_gemm_shell_ctrl against a transaction-level model
// of beat counts, slice order and busy-cycle accounting.
module tb_snax_gemm_shell_ctrl;

  localparam int NW = 512;
  localparam int CS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   csr_set [5];
  logic          csr_valid, csr_ready;
  logic [31:0]   ro [3];
  logic [511:0]  s0_data, s1_data, a_data, b_data;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic          a_valid, a_rdy, b_valid, b_rdy;
  logic          cfg_valid;
  logic [31:0]   core_m, core_k, core_n, core_sub;
  logic [2047:0] c_data;
  logic          c_valid, c_ready;
  logic [511:0]  acc_data;
  logic          acc_valid, acc_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snax_gemm_shell_ctrl dut (
    .clk_i (clk), .rst_ni (rst_n),
    .csr_reg_set_i (csr_set), .csr_reg_set_valid_i (csr_valid),
    .csr_reg_set_ready_o (csr_ready), .csr_reg_ro_set_o (ro),
    .stream2acc_0_data_i (s0_data), .stream2acc_0_valid_i (s0_valid),
    .stream2acc_0_ready_o (s0_ready),
    .stream2acc_1_data_i (s1_data), .stream2acc_1_valid_i (s1_valid),
    .stream2acc_1_ready_o (s1_ready),
    .core_a_data_o (a_data), .core_a_valid_o (a_valid), .core_a_ready_i (a_rdy),
    .core_b_data_o (b_data), .core_b_valid_o (b_valid), .core_b_ready_i (b_rdy),
    .core_cfg_valid_o (cfg_valid),
    .core_m_o (core_m), .core_k_o (core_k), .core_n_o (core_n), .core_sub_o (core_sub),
    .core_c_data_i (c_data), .core_c_valid_i (c_valid), .core_c_ready_o (c_ready),
    .acc2stream_0_data_o (acc_data), .acc2stream_0_valid_o (acc_valid),
    .acc2stream_0_ready_i (acc_ready)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [2047:0] rnd_c();
    logic [2047:0] v;
    for (int i = 0; i < 64; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [2047:0] pat_c();
    logic [2047:0] v;
    v = '0;
    for (int i = 0; i < CS; i++) v[i*NW +: NW] = NW'(i + 1);
    return v;
  endfunction

  task automatic quiet_inputs();
    csr_valid = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
    c_valid = 1'b0; acc_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_job(input int m, input int k, input int n, input bit drop,
                         input bit always_on, input int out_pct, input bit pattern,
                         input int abort_at);
    int mkn, mn, a_cnt, b_cnt, c_acc, cyc, t_last;
    int obs_a, obs_b, obs_c, obs_out;
    bit a_fire, b_fire, c_fire, out_fire, in_run, ea, eb, ecr, aborted, timed_out;
    logic [511:0]  slices[$];
    logic [2047:0] cur_c;
    logic [31:0]   sub;
    mkn = m * k * n; mn = m * n;
    a_cnt = 0; b_cnt = 0; c_acc = 0; cyc = 0; t_last = 0;
    obs_a = 0; obs_b = 0; obs_c = 0; obs_out = 0;
    aborted = 0; timed_out = 0;
    cur_c = pattern ? pat_c() : rnd_c();
    sub = $urandom();
    @(negedge clk);
    quiet_inputs();
    csr_set[0] = 32'(k); csr_set[1] = 32'(n); csr_set[2] = 32'(m);
    csr_set[3] = sub;    csr_set[4] = {31'b0, drop};
    csr_valid = 1'b1;
    #1 chk("cfg_ready", csr_ready, 1'b1);
    while (!(c_acc == mn && slices.size() == 0)) begin
      @(negedge clk);
      cyc++;
      csr_valid = 1'b0;
      if (cyc > 3000) begin
        chk("job_timeout", 32'(cyc), 0);
        timed_out = 1;
        break;
      end
      s0_valid  = always_on || ($urandom_range(0, 99) < 70);
      s1_valid  = always_on || ($urandom_range(0, 99) < 70);
      a_rdy     = always_on || ($urandom_range(0, 99) < 70);
      b_rdy     = always_on || ($urandom_range(0, 99) < 70);
      s0_data   = rnd512();
      s1_data   = rnd512();
      acc_ready = ($urandom_range(0, 99) < out_pct);
      c_valid   = 1'b0;
      #1;
      in_run = (c_acc < mn);
      ea = in_run && (a_cnt < mkn);
      eb = in_run && (b_cnt < mkn);
      chk("ab_gate", {a_valid, s0_ready, b_valid, s1_ready},
          {ea && s0_valid, ea && a_rdy, eb && s1_valid, eb && b_rdy});
      a_fire = ea && s0_valid && a_rdy;
      b_fire = eb && s1_valid && b_rdy;
      if (a_valid && a_rdy) begin obs_a++; chk("a_data", a_data, s0_data); end
      if (b_valid && b_rdy) begin obs_b++; chk("b_data", b_data, s1_data); end
      if (cyc == 1) begin
        chk("cfg_pulse", cfg_valid, 1'b1);
        chk("cfg_mkns", {core_m, core_k, core_n, core_sub}, {32'(m), 32'(k), 32'(n), sub});
        chk("status_clr", ro[2], 0);
        chk("perf_clr", ro[1], 0);
      end else begin
        chk("cfg_quiet", cfg_valid, 1'b0);
      end
      if (in_run && (a_cnt + int'(a_fire) >= mkn) && (b_cnt + int'(b_fire) >= mkn)) begin
        c_valid = always_on || ($urandom_range(0, 99) < 60);
        c_data  = cur_c;
      end
      #1;
      out_fire = (slices.size() > 0) && acc_ready;
      ecr = in_run && (drop || slices.size() == 0 || (slices.size() == 1 && out_fire));
      chk("c_ready", c_ready, ecr);
      chk("acc_valid", acc_valid, slices.size() > 0);
      if (slices.size() > 0) chk("acc_data", acc_data, slices[0]);
      if (acc_valid && acc_ready) obs_out++;
      if (c_valid && c_ready) obs_c++;
      c_fire = c_valid && ecr;
      if (a_fire) a_cnt++;
      if (b_fire) b_cnt++;
      if (out_fire) begin
        void'(slices.pop_front());
        t_last = cyc;
      end
      if (c_fire) begin
        c_acc++;
        if (drop) t_last = cyc;
        else for (int i = 0; i < CS; i++) slices.push_back(cur_c[i*NW +: NW]);
        cur_c = rnd_c();
      end
      if (abort_at > 0 && a_cnt >= abort_at) begin
        aborted = 1;
        break;
      end
    end
    if (timed_out) begin
      do_reset();
    end else if (aborted) begin
      @(negedge clk);
      c_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_kill", {a_valid, s0_ready, b_valid, acc_valid, cfg_valid, ro[0][0], csr_ready},
          7'b0000001);
      chk("rst_perf", ro[1], 0);
    end else begin
      @(negedge clk);
      quiet_inputs();
      #1 chk("drain_busy", {csr_ready, ro[0][0]}, 2'b01);
      @(negedge clk);
      #1;
      chk("back_idle", {csr_ready, ro[0][0]}, 2'b10);
      chk("perf", ro[1], 32'(t_last + 1));
      chk("status_end", ro[2], 0);
      chk("a_total", 32'(obs_a), 32'(mkn));
      chk("b_total", 32'(obs_b), 32'(mkn));
      chk("c_total", 32'(obs_c), 32'(mn));
      chk("out_total", 32'(obs_out), drop ? 0 : 32'(mn * CS));
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) csr_set[i] = '0;
    s0_data = '0; s1_data = '0; c_data = '0;
    quiet_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1; a_rdy = 1'b1; b_rdy = 1'b1;
    #1;
    chk("rst_state", {csr_ready, ro[0][0], cfg_valid, a_valid, s0_ready, b_valid, s1_ready,
                      c_ready, acc_valid}, 9'b1_0000_0000);
    chk("rst_ro", {ro[1], ro[2], core_m, core_k, core_n}, 0);

    run_job(1, 1, 1, 1'b0, 1'b1, 100, 1'b1, 0);
    run_job(2, 3, 2, 1'b0, 1'b1, 100, 1'b0, 0);

    // zero-dimension configuration
    @(negedge clk);
    quiet_inputs();
    csr_set[0] = 32'd0; csr_set[1] = 32'd3; csr_set[2] = 32'd2; csr_set[4] = 32'd0;
    csr_valid = 1'b1;
    #1 chk("zero_ready", csr_ready, 1'b1);
    @(negedge clk);
    csr_valid = 1'b0;
    #1;
    chk("zero_nopulse", cfg_valid, 1'b0);
    chk("zero_status", {ro[2], ro[0], 31'b0, csr_ready}, {32'd1, 32'd0, 32'd1});
    @(negedge clk);
    #1 chk("zero_idle", {cfg_valid, ro[0][0]}, 2'b00);

    // C valid in IDLE is refused and flagged
    @(negedge clk);
    c_valid = 1'b1;
    c_data  = rnd_c();
    #1 chk("idle_c_ready", c_ready, 1'b0);
    @(negedge clk);
    c_valid = 1'b0;
    #1 chk("overrun", ro[2], 32'd3);

    run_job(2, 1, 3, 1'b0, 1'b1, 50, 1'b0, 0);
    run_job(2, 2, 2, 1'b1, 1'b1, 100, 1'b0, 0);
    run_job(2, 2, 2, 1'b0, 1'b1, 100, 1'b0, 5);
    run_job(1, 1, 1, 1'b0, 1'b1, 100, 1'b1, 0);

    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(30, 100), 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
